// File: rtl/sram_pkg.sv
// Shared constants for the SRAM line engine.
// Holds the SRAM geometry, the request widths, the default memory base,
// the FSM state encoding, and the byte-address to halfword-index helper.
package sram_pkg;

  localparam int SRAM_AW          = 18;    // halfword address bits on the pins
  localparam int SRAM_DW          = 16;    // SRAM data bus width
  localparam int WORD_W           = 32;    // cache write word
  localparam int LINE_W           = 64;    // cache read line
  localparam int MEM_BASE_DEFAULT = 1024;  // byte address of SRAM halfword 0

  // FSM state encoding
  localparam logic [1:0] ST_IDLE   = 2'd0;
  localparam logic [1:0] ST_ACCESS = 2'd1;
  localparam logic [1:0] ST_DONE   = 2'd2;

  // Byte address to halfword index; the truncation to SRAM_AW bits gives the
  // modulo-2^18 wrap for free.
  function automatic logic [SRAM_AW-1:0] hw_index(input logic [31:0] address,
                                                  input logic [31:0] base);
    return SRAM_AW'((address - base) >> 1);
  endfunction

endpackage

// File: rtl/sram_phase_timer.sv
// Phase timer for the SRAM line engine.
// Each 16-bit SRAM phase lasts WAIT_CYCLES clocks. A down-counter reloads at
// the start of every phase; last_clk flags the terminal clock of the phase
// and phase counts which 16-bit slice is being transferred.
// Ports:
//   clk, rst  - clock, asynchronous active-high reset
//   start     - load the first phase (IDLE -> ACCESS transition)
//   run       - engine is in ACCESS
//   last_clk  - current clock is the last one of the current phase
//   phase     - current phase index 0..3
module sram_phase_timer #(
  parameter int WAIT_CYCLES = 1
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       start,
  input  logic       run,
  output logic       last_clk,
  output logic [1:0] phase
);

  localparam int CW = (WAIT_CYCLES > 1) ? $clog2(WAIT_CYCLES) : 1;
  localparam logic [CW-1:0] RELOAD = CW'(WAIT_CYCLES - 1);

  logic [CW-1:0] wait_cnt;

  assign last_clk = run && (wait_cnt == '0);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wait_cnt <= '0;
      phase    <= '0;
    end else if (start) begin
      wait_cnt <= RELOAD;
      phase    <= '0;
    end else if (run) begin
      if (wait_cnt == '0) begin
        wait_cnt <= RELOAD;
        phase    <= phase + 2'd1;
      end else begin
        wait_cnt <= wait_cnt - CW'(1);
      end
    end
  end

endmodule

// File: rtl/sram_line_engine.sv
// SRAM line engine: memory-side responder for the data cache.
// Takes one 32-bit word write or one 64-bit line read at a time and splits it
// into 16-bit SRAM accesses, each held for WAIT_CYCLES clocks.
// Optional feature macro: SRAM_ADDR_CHECK_EN adds the addr_err output and
// rejects requests outside [MEM_BASE, MEM_BASE + 2^19) without touching the pins.
// Ports:
//   clk, rst          - clock, asynchronous active-high reset
//   write, read       - requests, held until ready (write wins when both high)
//   address, wdata    - byte address and write word
//   rdata             - line read data, valid in DONE, held until next read
//   ready             - idle with no request, or DONE
//   sram_dq           - bidirectional SRAM data bus
//   sram_address      - SRAM halfword address
//   SRAM_*_N          - SRAM controls; only SRAM_WE_N toggles
//   addr_err          - (SRAM_ADDR_CHECK_EN only) out-of-range request, in DONE
//
// state  | meaning
// IDLE   | waiting; samples and latches a request
// ACCESS | stepping through 2 (write) or 4 (read) SRAM phases
// DONE   | one clock; ready high, rdata valid
module sram_line_engine
  import sram_pkg::*;
#(
  parameter int WAIT_CYCLES = 1,
  parameter int MEM_BASE    = MEM_BASE_DEFAULT
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               write,
  input  logic               read,
  input  logic [WORD_W-1:0]  address,
  input  logic [WORD_W-1:0]  wdata,
  output logic [LINE_W-1:0]  rdata,
  output logic               ready,
  inout  wire  [SRAM_DW-1:0] sram_dq,
  output logic [SRAM_AW-1:0] sram_address,
  output logic               SRAM_UB_N,
  output logic               SRAM_LB_N,
  output logic               SRAM_CE_N,
  output logic               SRAM_OE_N,
  output logic               SRAM_WE_N
`ifdef SRAM_ADDR_CHECK_EN
  ,
  output logic               addr_err
`endif
);

  // With a single-clock phase there is no spare clock to hold address/data
  // after the strobe, so WE_N stays low for the whole phase.
  localparam bit SINGLE_CLK = (WAIT_CYCLES == 1);

  logic [1:0]         state;
  logic               op_write;
  logic [WORD_W-1:0]  wdata_q;
  logic               last_clk;
  logic [1:0]         phase;
  logic               req;
  logic               addr_bad;
  logic               start;
  logic               in_access;
  logic               last_phase;
  logic               drive;
  logic [SRAM_AW-1:0] hw;

  assign req        = write | read;
  assign in_access  = (state == ST_ACCESS);
  assign last_phase = op_write ? (phase == 2'd1) : (phase == 2'd3);
  assign hw         = hw_index(address, 32'(MEM_BASE));

`ifdef SRAM_ADDR_CHECK_EN
  assign addr_bad = ({1'b0, address} < 33'(MEM_BASE)) ||
                    ({1'b0, address} >= (33'(MEM_BASE) + 33'(2 ** 19)));
`else
  assign addr_bad = 1'b0;
`endif

  assign start = (state == ST_IDLE) && req && !addr_bad;

  sram_phase_timer #(.WAIT_CYCLES(WAIT_CYCLES)) u_timer (
    .clk      (clk),
    .rst      (rst),
    .start    (start),
    .run      (in_access),
    .last_clk (last_clk),
    .phase    (phase)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state        <= ST_IDLE;
      op_write     <= 1'b0;
      wdata_q      <= '0;
      sram_address <= '0;
      rdata        <= '0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (req) begin
            op_write <= write;
            if (addr_bad) begin
              state <= ST_DONE;
              if (!write) rdata <= '0;
            end else begin
              state        <= ST_ACCESS;
              wdata_q      <= wdata;
              sram_address <= write ? {hw[SRAM_AW-1:1], 1'b0}
                                    : {hw[SRAM_AW-1:2], 2'b00};
            end
          end
        end
        ST_ACCESS: begin
          if (last_clk) begin
            if (!op_write) rdata[{phase, 4'b0000} +: SRAM_DW] <= sram_dq;
            if (last_phase) state <= ST_DONE;
            else            sram_address <= sram_address + SRAM_AW'(1);
          end
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

`ifdef SRAM_ADDR_CHECK_EN
  always_ff @(posedge clk or posedge rst) begin
    if (rst) addr_err <= 1'b0;
    else     addr_err <= (state == ST_IDLE) && req && addr_bad;
  end
`endif

  // Pin drive is decoded from state so reset releases the bus and raises
  // WE_N asynchronously, in the same clock it is asserted.
  assign drive     = in_access && op_write;
  assign SRAM_WE_N = ~(drive && (SINGLE_CLK || !last_clk));
  assign sram_dq   = drive ? (phase[0] ? wdata_q[31:16] : wdata_q[15:0])
                           : {SRAM_DW{1'bz}};

  assign SRAM_UB_N = 1'b0;
  assign SRAM_LB_N = 1'b0;
  assign SRAM_CE_N = 1'b0;
  assign SRAM_OE_N = 1'b0;

  assign ready = ((state == ST_IDLE) && !req) || (state == ST_DONE);

endmodule
